// File: rtl/seg_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_add_pkg
// Description : Shared types and default constants for the segmented adder
//               engine: FSM state encoding and default chunk geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_add_pkg;

    // Default geometry: 4 chunks of 12 bits gives a 48-bit operand.
    localparam int c_CHUNK_W_DEF    = 12;
    localparam int c_NUM_CHUNKS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cla_chunk.sv
`default_nettype none
// ============================================================================
// Module      : cla_chunk
// Description : WIDTH-bit carry-lookahead adder. Every carry is computed
//               directly from the generate/propagate terms and cin, so no
//               carry ripples from one bit to the next.
// Ports       : a, b  - addends
//               cin   - carry in
//               s     - sum
//               cout  - carry out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module cla_chunk #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;

    // Carry into bit n+1: g[n] | p[n]g[n-1] | ... | p[n..0]cin
    function automatic logic f_lookahead(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic             c0,
        input int               n
    );
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        for (int k = n; k >= 0; k--) begin
            acc = acc | (pp & g[k]);
            pp  = pp & p[k];
        end
        return acc | (pp & c0);
    endfunction

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign w_c[i+1] = f_lookahead(w_g, w_p, cin, i);
    end

    assign s    = w_p ^ w_c[WIDTH-1:0];
    assign cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/seg_add_engine.sv
`default_nettype none
// ============================================================================
// Module      : seg_add_engine
// Description : Adds two wide operands one chunk per cycle, least significant
//               chunk first, chaining the carry between chunks. The result is
//               assembled in place and held until the next accepted start.
// Ports       : clk, rst (async, active-low)
//               start, abort          - control (abort has top priority)
//               chunk_valid, a_chunk, b_chunk - operand chunk stream
//               chunk_req, chunk_idx  - chunk handshake / next index
//               busy                  - high in LOAD or DONE
//               sum, carry_out, result_valid - result
//               sub (SEG_ADD_SUB_EN only) - subtract A - B, sampled at start
// Config      : `define SEG_ADD_SUB_EN adds the sub port and A - B mode.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_add_engine
    import seg_add_pkg::*;
#(
    parameter int CHUNK_W    = c_CHUNK_W_DEF,
    parameter int NUM_CHUNKS = c_NUM_CHUNKS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef SEG_ADD_SUB_EN
    input  logic                          sub,
`endif
    input  logic                          start,
    input  logic                          abort,
    input  logic                          chunk_valid,
    input  logic [CHUNK_W-1:0]            a_chunk,
    input  logic [CHUNK_W-1:0]            b_chunk,
    output logic                          chunk_req,
    output logic [$clog2(NUM_CHUNKS)-1:0] chunk_idx,
    output logic                          busy,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] sum,
    output logic                          carry_out,
    output logic                          result_valid
);

    localparam int                IDX_W      = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          carry_q, carry_d;
    logic                          cout_q, cout_d;
    logic [CHUNK_W*NUM_CHUNKS-1:0] sum_q, sum_d;

    logic                          w_start;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_seed;
    logic [CHUNK_W-1:0]            w_b;
    logic [CHUNK_W-1:0]            w_s;
    logic                          w_co;

`ifdef SEG_ADD_SUB_EN
    logic                          sub_q, sub_d;

    // Subtraction is A + ~B + 1: invert B per chunk, seed the carry with 1.
    assign w_b    = sub_q ? ~b_chunk : b_chunk;
    assign w_seed = sub;
`else
    assign w_b    = b_chunk;
    assign w_seed = 1'b0;
`endif

    // Abort outranks both start and chunk acceptance.
    assign w_start  = (state_q == ST_IDLE) && start && !abort;
    assign w_accept = (state_q == ST_LOAD) && chunk_valid && !abort;
    assign w_last   = (idx_q == c_LAST_IDX);

    cla_chunk #(
        .WIDTH (CHUNK_W)
    ) u_cla (
        .a    (a_chunk),
        .b    (w_b),
        .cin  (carry_q),
        .s    (w_s),
        .cout (w_co)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start)            state_d = ST_LOAD;
            ST_LOAD: if (abort)              state_d = ST_IDLE;
                     else if (w_accept && w_last) state_d = ST_DONE;
            ST_DONE:                         state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        chunk_req    = (state_q == ST_LOAD);
        busy         = (state_q == ST_LOAD) || (state_q == ST_DONE);
        // An abort landing on the DONE cycle suppresses the result pulse.
        result_valid = (state_q == ST_DONE) && !abort;
    end

    // ---------------- Datapath ----------------
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sum_d   = sum_q;
`ifdef SEG_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        if (abort) begin
            idx_d = '0;
        end else if (w_start) begin
            idx_d   = '0;
            carry_d = w_seed;
            cout_d  = 1'b0;
            sum_d   = '0;
`ifdef SEG_ADD_SUB_EN
            sub_d   = sub;
`endif
        end else if (w_accept) begin
            sum_d[int'(idx_q)*CHUNK_W +: CHUNK_W] = w_s;
            carry_d = w_co;
            // The index parks on the last chunk rather than wrapping.
            if (w_last) begin
                cout_d = w_co;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
`ifdef SEG_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
`ifdef SEG_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign chunk_idx = idx_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_add_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_add_engine
// Description : Self-checking bench for seg_add_engine (48-bit default
//               geometry). Expected results come from plain 49-bit
//               arithmetic and are queued at start; a monitor pops and
//               compares each result_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_add_engine;

`ifdef SEG_ADD_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sub;
    logic        start;
    logic        abort;
    logic        chunk_valid;
    logic [11:0] a_chunk;
    logic [11:0] b_chunk;
    logic        chunk_req;
    logic [1:0]  chunk_idx;
    logic        busy;
    logic [47:0] sum;
    logic        carry_out;
    logic        result_valid;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [48:0] exp_q[$];

    seg_add_engine dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SEG_ADD_SUB_EN
        .sub          (sub),
`endif
        .start        (start),
        .abort        (abort),
        .chunk_valid  (chunk_valid),
        .a_chunk      (a_chunk),
        .b_chunk      (b_chunk),
        .chunk_req    (chunk_req),
        .chunk_idx    (chunk_idx),
        .busy         (busy),
        .sum          (sum),
        .carry_out    (carry_out),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_valid", 64'(result_valid), 64'd0);
            end else begin
                logic [48:0] e;
                e = exp_q.pop_front();
                chk("sum", 64'(sum), 64'(e[47:0]));
                chk("carry_out", 64'(carry_out), 64'(e[48]));
            end
        end
    end

    // One operation. stall_at: chunk index preceded by stall_len idle cycles
    // (>=4 means no stall). abort_after: chunk index after which abort is
    // raised (<0 means run to completion). hold_start keeps start high while
    // busy, which must be ignored.
    task automatic do_op(input logic [47:0] a, input logic [47:0] b, input logic s_in,
                         input int stall_at, input int stall_len,
                         input int abort_after, input bit hold_start);
        int          n0;
        int          last_k;
        int          slen;
        bit          got;
        logic        s;
        logic [48:0] r;
        s = s_in & HAS_SUB;
        if (s) r = {1'b0, a} + {1'b0, ~b} + 49'd1;
        else   r = {1'b0, a} + {1'b0, b};
        if (abort_after < 0) exp_q.push_back(r);
        slen = (stall_at < 4) ? stall_len : 0;

        start = 1'b1; sub = s; chunk_valid = 1'b0;
        n0 = cyc;
        @(posedge clk); #1;
        start = hold_start;
        chk("busy_after_start", 64'(busy), 64'd1);
        last_k = (abort_after < 0) ? 3 : abort_after;
        for (int k = 0; k <= last_k; k++) begin
            if (k == stall_at) begin
                chunk_valid = 1'b0;
                a_chunk = 12'($urandom); b_chunk = 12'($urandom);
                for (int j = 0; j < stall_len; j++) begin
                    @(posedge clk); #1;
                end
            end
            chk("chunk_idx", 64'(chunk_idx), 64'(k));
            chunk_valid = 1'b1;
            a_chunk = a[k*12 +: 12];
            b_chunk = b[k*12 +: 12];
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        chunk_valid = 1'b0;
        start = 1'b0;

        if (abort_after >= 0) begin
            abort = 1'b1; chunk_valid = 1'b1; start = 1'b1;
            a_chunk = 12'($urandom); b_chunk = 12'($urandom);
            @(negedge clk);
            chk("abort_no_result", 64'(result_valid), 64'd0);
            @(posedge clk); #1;
            abort = 1'b0; chunk_valid = 1'b0; start = 1'b0;
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_chunk_req", 64'(chunk_req), 64'd0);
            chk("abort_chunk_idx", 64'(chunk_idx), 64'd0);
        end else begin
            got = 1'b0;
            for (int w = 0; w < 30; w++) begin
                @(negedge clk);
                if (result_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("result_seen", 64'(got), 64'd1);
            chk("result_cycle", 64'(cyc - n0), 64'(5 + slen));
            @(posedge clk); #1;
            chk("idle_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0; sub = 1'b0; start = 1'b0; abort = 1'b0;
        chunk_valid = 1'b0; a_chunk = '0; b_chunk = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry_out", 64'(carry_out), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_chunk_req", 64'(chunk_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chunk_idx", 64'(chunk_idx), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Carry across one chunk boundary, start held high while busy.
        do_op(48'h000000000FFF, 48'h000000000001, 1'b0, 4, 0, -1, 1'b1);
        // Carry ripples across every chunk and out of the top.
        do_op(48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0, 4, 0, -1, 1'b0);
        // Three stall cycles before chunk 2.
        do_op(48'h123456789ABC, 48'h0FEDCBA98765, 1'b0, 2, 3, -1, 1'b0);

        // Asynchronous reset while chunk 2 is being presented.
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chunk_valid = 1'b1; a_chunk = 12'hABC; b_chunk = 12'h321;
            @(posedge clk); #1;
        end
        chunk_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_carry_out", 64'(carry_out), 64'd0);
        chk("mid_rst_chunk_req", 64'(chunk_req), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_chunk_idx", 64'(chunk_idx), 64'd0);
        chk("mid_rst_result_valid", 64'(result_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; chunk_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        do_op(48'h800000000000, 48'h800000000001, 1'b0, 4, 0, -1, 1'b0);

        // Abort after chunk 1, start held while busy.
        do_op(48'h111111111111, 48'h222222222222, 1'b0, 4, 0, 1, 1'b1);
        // Next operation after an abort must still be correct.
        do_op(48'h00000000FFFF, 48'h00000000FFFF, 1'b0, 4, 0, -1, 1'b0);

`ifdef SEG_ADD_SUB_EN
        do_op(48'h000000000005, 48'h000000000007, 1'b1, 4, 0, -1, 1'b0);
        do_op(48'h000000000007, 48'h000000000005, 1'b1, 1, 2, -1, 1'b0);
`endif

        for (int i = 0; i < 25; i++) begin
            logic [47:0] ra;
            logic [47:0] rb;
            int          ab;
            ra = {16'($urandom), 32'($urandom)};
            rb = {16'($urandom), 32'($urandom)};
            if (i % 5 == 0) ra = ~48'h0;
            if (i % 7 == 0) rb = ~ra;
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            // Stray chunks in IDLE must be ignored.
            chunk_valid = 1'b1; a_chunk = 12'($urandom); b_chunk = 12'($urandom);
            @(posedge clk); #1;
            chunk_valid = 1'b0;
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 5), $urandom_range(1, 3), ab,
                  1'($urandom));
        end

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
